// File: rtl/cmp_seq_pkg.sv
// Shared constants for the bit-serial magnitude comparator.
package cmp_seq_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bit_cmp_slice.sv
// Single bit-pair comparison: greater-than and equality of one bit position.
module bit_cmp_slice (
  input  logic ai,
  input  logic bi,
  output logic gt_i,
  output logic eq_i
);

  assign gt_i = ai & ~bi;
  assign eq_i = ~(ai ^ bi);

endmodule

// File: rtl/compare_sequencer.sv
// Bit-serial MSB-first magnitude comparator: one bit pair per cycle.
module compare_sequencer
  import cmp_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  output logic                       busy,
  output logic                       done,
  output logic                       ge,
  output logic                       gt,
  output logic                       eq,
  output logic [$clog2(WIDTH+1)-1:0] nbits
);

  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam int unsigned NB_W  = $clog2(WIDTH + 1);

  state_t             state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [IDX_W-1:0]   idx;
  logic [NB_W-1:0]    cnt;
  logic               gt_bit;
  logic               eq_bit;
  logic [NB_W-1:0]    cnt_inc;

  // Bit pair currently under examination.
  bit_cmp_slice u_slice (
    .ai   (a_q[idx]),
    .bi   (b_q[idx]),
    .gt_i (gt_bit),
    .eq_i (eq_bit)
  );

  assign cnt_inc = cnt + NB_W'(1);

  // Sequencer: accept operands, walk bits MSB first, publish result for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      idx   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      ge    <= 1'b0;
      gt    <= 1'b0;
      eq    <= 1'b0;
      nbits <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            idx   <= IDX_W'(WIDTH - 1);
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          cnt <= cnt_inc;
          if (!eq_bit) begin
            // First differing bit decides: a wins exactly when its bit is the 1.
            gt    <= gt_bit;
            ge    <= gt_bit;
            eq    <= 1'b0;
            nbits <= cnt_inc;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (idx == '0) begin
            gt    <= 1'b0;
            ge    <= 1'b1;
            eq    <= 1'b1;
            nbits <= cnt_inc;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx - IDX_W'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_compare_sequencer.sv
// Self-checking bench for compare_sequencer (WIDTH=8).
module tb_compare_sequencer;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic       ge;
  logic       gt;
  logic       eq;
  logic [3:0] nbits;

  int n_cmp = 0;
  int n_bad = 0;

  compare_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .ge    (ge),
    .gt    (gt),
    .eq    (eq),
    .nbits (nbits)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ge;
    logic       gt;
    logic       eq;
    int         nb;
  } vec_t;

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: ordinary integer comparison; examined count is W minus the
  // position of the highest differing bit (all W when equal).
  task automatic model(input logic [7:0] x, input logic [7:0] y,
                       output logic m_ge, output logic m_gt, output logic m_eq,
                       output int m_nb);
    logic [7:0] diff;
    diff = x ^ y;
    m_ge = (x >= y);
    m_gt = (x > y);
    m_eq = (x == y);
    m_nb = W;
    for (int i = 0; i < W; i++)
      if (diff[i]) m_nb = W - i;
  endtask

  // Start one comparison from IDLE (called #1 after an edge); returns the
  // cycle number (after acceptance) in which done was seen, or -1.
  task automatic run_cmp(input logic [7:0] a0, input logic [7:0] b0, input bit perturb,
                         output int lat, output logic r_ge, output logic r_gt,
                         output logic r_eq, output int r_nb);
    bit overlap = 0;
    bit busy_bad = 0;
    lat = -1;
    r_ge = 0; r_gt = 0; r_eq = 0; r_nb = -1;
    a = a0; b = b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= W + 3 && lat < 0; k++) begin
      if (!busy) busy_bad = 1;
      if (perturb) begin
        a = 8'($urandom); b = 8'($urandom); start = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      if (busy && done) overlap = 1;
      if (done) begin
        lat = k + 1;
        r_ge = ge; r_gt = gt; r_eq = eq; r_nb = int'(nbits);
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("busy_during_run", int'(busy_bad), 0);
    chk("busy_done_overlap", int'(overlap), 0);
    @(posedge clk); #1;
    chk("done_one_cycle", int'(done), 0);
    chk("idle_busy", int'(busy), 0);
  endtask

  vec_t vecs[7];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat, nb, m_nb, dones;
    logic r_ge, r_gt, r_eq, m_ge, m_gt, m_eq;
    logic [7:0] x, y;

    vecs[0] = '{8'h80, 8'h7F, 1'b1, 1'b1, 1'b0, 1};
    vecs[1] = '{8'h55, 8'h55, 1'b1, 1'b0, 1'b1, 8};
    vecs[2] = '{8'h3C, 8'h34, 1'b1, 1'b1, 1'b0, 5};
    vecs[3] = '{8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 8};
    vecs[4] = '{8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 8};
    vecs[5] = '{8'hFF, 8'h00, 1'b1, 1'b1, 1'b0, 1};
    vecs[6] = '{8'h10, 8'h20, 1'b0, 1'b0, 1'b0, 3};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ge", int'(ge), 0);
    chk("rst_gt", int'(gt), 0);
    chk("rst_eq", int'(eq), 0);
    chk("rst_nbits", int'(nbits), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table: latency is cycle nbits+1 after acceptance.
    for (int i = 0; i < 7; i++) begin
      run_cmp(vecs[i].a, vecs[i].b, 1'b0, lat, r_ge, r_gt, r_eq, nb);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].nb + 1);
      chk($sformatf("vec%0d_ge", i), int'(r_ge), int'(vecs[i].ge));
      chk($sformatf("vec%0d_gt", i), int'(r_gt), int'(vecs[i].gt));
      chk($sformatf("vec%0d_eq", i), int'(r_eq), int'(vecs[i].eq));
      chk($sformatf("vec%0d_nbits", i), nb, vecs[i].nb);
    end

    // Results hold while idle with inputs moving and no start.
    repeat (5) begin
      a = 8'($urandom); b = 8'($urandom);
      @(posedge clk); #1;
    end
    chk("hold_ge", int'(ge), 0);
    chk("hold_gt", int'(gt), 0);
    chk("hold_eq", int'(eq), 0);
    chk("hold_nbits", int'(nbits), 3);

    // Random operands, perturbed inputs and stray starts during RUN.
    for (int i = 0; i < 40; i++) begin
      x = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       y = x;
        1:       y = x ^ (8'd1 << $urandom_range(0, 7));
        default: y = 8'($urandom);
      endcase
      model(x, y, m_ge, m_gt, m_eq, m_nb);
      run_cmp(x, y, 1'b1, lat, r_ge, r_gt, r_eq, nb);
      chk($sformatf("rnd%0d_latency a=%02h b=%02h", i, x, y), lat, m_nb + 1);
      chk($sformatf("rnd%0d_ge", i), int'(r_ge), int'(m_ge));
      chk($sformatf("rnd%0d_gt", i), int'(r_gt), int'(m_gt));
      chk($sformatf("rnd%0d_eq", i), int'(r_eq), int'(m_eq));
      chk($sformatf("rnd%0d_nbits", i), nb, m_nb);
    end

    // start held high through RUN/DONE with a changed: no restart until IDLE.
    a = 8'h00; b = 8'h01; start = 1'b1;
    @(posedge clk); #1;
    a = 8'hFF;
    dones = 0; lat = -1;
    for (int k = 1; k <= W + 3 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (done) begin
        dones++; lat = k + 1;
        r_ge = ge; r_gt = gt; r_eq = eq; nb = int'(nbits);
      end
    end
    chk("held_latency", lat, 9);
    chk("held_ge", int'(r_ge), 0);
    chk("held_gt", int'(r_gt), 0);
    chk("held_eq", int'(r_eq), 0);
    chk("held_nbits", nb, 8);
    @(posedge clk); #1;
    chk("held_idle_done", int'(done), 0);
    chk("held_idle_busy", int'(busy), 0);
    chk("held_done_pulses", dones, 1);
    @(posedge clk); #1;
    chk("held_restart_busy", int'(busy), 1);
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= W + 3 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k + 1;
        r_ge = ge; r_gt = gt; r_eq = eq; nb = int'(nbits);
      end
    end
    chk("second_latency", lat, 2);
    chk("second_ge", int'(r_ge), 1);
    chk("second_gt", int'(r_gt), 1);
    chk("second_nbits", nb, 1);
    @(posedge clk); #1;

    // Reset three cycles into RUN aborts without a done pulse.
    a = 8'h55; b = 8'h55; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_busy", int'(busy), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_done", int'(done), 0);
    chk("async_rst_ge", int'(ge), 0);
    chk("async_rst_gt", int'(gt), 0);
    chk("async_rst_eq", int'(eq), 0);
    chk("async_rst_nbits", int'(nbits), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    dones = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("abort_no_done", dones, 0);
    run_cmp(8'h01, 8'h00, 1'b0, lat, r_ge, r_gt, r_eq, nb);
    chk("post_rst_latency", lat, 9);
    chk("post_rst_ge", int'(r_ge), 1);
    chk("post_rst_gt", int'(r_gt), 1);
    chk("post_rst_eq", int'(r_eq), 0);
    chk("post_rst_nbits", nb, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/compare_sequencer.md
COMPARE_SEQUENCER -- requirements
Module: compare_sequencer

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits, minimum 2.
REQ-002 clk  input  1  the single clock; all state changes on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a comparison; sampled only in IDLE.
REQ-005 a  input  WIDTH  first operand; sampled on the edge that accepts start.
REQ-006 b  input  WIDTH  second operand; sampled on the edge that accepts start.
REQ-007 busy  output  1  high while a comparison is in progress (RUN state).
REQ-008 done  output  1  one-cycle pulse when results become valid.
REQ-009 ge  output  1  result a >= b.
REQ-010 gt  output  1  result a > b.
REQ-011 eq  output  1  result a == b.
REQ-012 nbits  output  clog2(WIDTH+1)  count of bit positions examined in the last comparison.

Function
REQ-013 States SHALL be IDLE, RUN and DONE.
REQ-014 In IDLE with start=1, the block SHALL latch a and b, set index to WIDTH-1, clear the examined count and enter RUN on the same edge.
REQ-015 In IDLE with start=0, the block SHALL remain in IDLE.
REQ-016 In RUN, each cycle SHALL compare one bit pair at index, MSB first, through the bit slice, and increment the examined count.
REQ-017 In RUN, if the bits differ, the block SHALL decide gt = latched a[index], eq=0, ge=gt, and enter DONE.
REQ-018 In RUN, if the bits are equal and index=0, the block SHALL decide eq=1, gt=0, ge=1, and enter DONE.
REQ-019 In RUN, if the bits are equal and index>0, the block SHALL decrement index and stay in RUN.
REQ-020 ge, gt, eq and nbits SHALL be registered and update only on the edge that enters DONE.
REQ-021 These outputs SHALL hold their value until the next comparison completes.
REQ-022 done SHALL be 1 exactly during the DONE cycle; DONE SHALL return to IDLE unconditionally after one cycle.
REQ-023 Latency: with n bits examined (1..WIDTH), done SHALL be high in cycle n+1 after the accepting edge.
REQ-024 start while in RUN or DONE SHALL be ignored: no restart, no queuing, and operands are not re-sampled.
REQ-025 Changes on a or b after acceptance SHALL NOT affect the result.
REQ-026 busy SHALL be 1 in RUN only; busy and done SHALL never both be 1.

Reset
REQ-027 On rst=1, the block SHALL immediately enter IDLE, regardless of state or clock.
REQ-028 On rst=1, the block SHALL clear busy, done, ge, gt, eq, nbits, index and the latched operands to 0.
REQ-029 Reset asserted mid-RUN SHALL abort the comparison with no done pulse.
REQ-030 The first start after reset deasserts SHALL be accepted normally.

Structure
REQ-031 A shared package cmp_seq_pkg SHALL hold the state encoding constants (IDLE, RUN, DONE) and the default WIDTH.
REQ-032 A sub-module bit_cmp_slice SHALL be instantiated once.
REQ-033 bit_cmp_slice SHALL be combinational, with inputs ai and bi and outputs gt_i = ai & ~bi and eq_i = ~(ai ^ bi).
REQ-034 The FSM, index counter and result registers SHALL reside in compare_sequencer.

Verification (WIDTH=8)
REQ-035 a=0x80, b=0x7F, start pulse -> done 2 cycles later; ge=1, gt=1, eq=0, nbits=1.
REQ-036 a=0x55, b=0x55 -> done 9 cycles after acceptance; ge=1, gt=0, eq=1, nbits=8.
REQ-037 a=0x3C, b=0x34 -> decision at bit 3; ge=1, gt=1, eq=0, nbits=5, done 6 cycles after acceptance.
REQ-038 a=0x00, b=0x01 -> ge=0, gt=0, eq=0, nbits=8; then start held high through RUN with a=0xFF -> the result is unchanged, exactly one done pulse occurs, and the next comparison begins only once back in IDLE.
REQ-039 a=0x55, b=0x55, rst pulsed 3 cycles into RUN -> all outputs 0 immediately, no done pulse; a subsequent start with a=0x01, b=0x00 -> ge=1, gt=1, nbits=8.
